pdshank_acq_sequencer: RTL and testbench
========================================

# pdshank_acq_sequencer

Acquisition sequencer that configures and runs the pdShank readout FSM. It latches host configuration into shadow registers and drives the readout FSM's enable and reset. It counts completed frames and stops after N frames or on request. It also throttles frame starts on FIFO almost-full and recovers from hung frames with a watchdog. It sits between the host wire-in/trigger interface and the readout FSM, inside the `clk_in` domain.

## Interface
- RST_CYCLES, 4: cycles `rd_rst_o` is held high in ARM and ABORT.
- MAX_ROWS, 800: largest legal `cfg_num_rows`; use 400 for the half-array chip build.
- clk_in  in  1  readout clock (same clock as the readout FSM).
- fsm_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins acquisition from IDLE.
- stop  in  1  one-cycle pulse; graceful stop at the next frame boundary.
- cfg_update  in  1  one-cycle pulse; requests a shadow reload at the next frame boundary.
- continuous  in  1  1 = ignore `cfg_num_frames`.
- cfg_num_frames  in  16  frames per acquisition; 0 is treated as 1.
- cfg_num_rows  in  10  rows per frame.
- cfg_integration  in  32  integration period.
- cfg_periods  in  60  packed {global_rst, transfer, sel_row, count_row, reset_row, count_reset_row}, 10 b each, MSB first.
- cfg_data_wait  in  4  data-wait cycles.
- cfg_timeout  in  32  maximum cycles per frame; 0 disables the watchdog.
- frame_count  in  10  `frameCount` from the readout FSM.
- fifo_afull  in  1  readout FIFO almost-full.
- fsm_en_o  out  1  drives the readout FSM `fsm_en`.
- rd_rst_o  out  1  drives the readout FSM `fsm_rst`.
- sh_num_rows  out  10  shadowed `cfg_num_rows`.
- sh_integration  out  32  shadowed `cfg_integration`.
- sh_periods  out  60  shadowed `cfg_periods`.
- sh_data_wait  out  4  shadowed `cfg_data_wait`.
- frames_done  out  16  frames completed in the current acquisition.
- busy  out  1  1 when the state is not IDLE.
- err_cfg  out  1  sticky; start was rejected because of invalid configuration.
- err_timeout  out  1  sticky; the watchdog fired.

## Operation
- States: IDLE, ARM, RUN, HOLD, RELOAD, ABORT.
- IDLE:
  - `fsm_en_o` = 0 and `rd_rst_o` = 0.
  - On `start`, configuration is valid when 1 ≤ `cfg_num_rows` ≤ MAX_ROWS.
  - Valid: capture all `sh_*`, clear `frames_done`, clear `err_cfg`/`err_timeout`, clear `stop_pend`/`upd_pend`, go to ARM.
  - Invalid: set `err_cfg`, stay in IDLE.
- ARM:
  - `rd_rst_o` = 1 for RST_CYCLES cycles.
  - Load `prev_fc` with 0, then go to RUN.
- RUN:
  - `fsm_en_o` = 1; the watchdog counter increments every cycle.
  - Frame boundary: `frame_count` != `prev_fc`. Any change counts, including 1023→0 wrap.
  - On a boundary: `prev_fc` ← `frame_count`, `frames_done`++ (saturates at 0xFFFF), watchdog cleared.
  - Exits from RUN on a boundary, in priority order:
    1. `stop_pend`, or (!`continuous` and `frames_done`+1 ≥ max(`cfg_num_frames`,1)) → IDLE.
    2. `upd_pend` → RELOAD.
    3. `fifo_afull` → HOLD.
    4. Otherwise stay in RUN.
  - Watchdog: `cfg_timeout` ≠ 0 and counter ≥ `cfg_timeout` → set `err_timeout`, go to ABORT.
- HOLD:
  - `fsm_en_o` = 0; the readout FSM parks before global reset.
  - Return to RUN when `fifo_afull` = 0. If `stop_pend` is set, go to IDLE instead.
  - The watchdog is frozen.
- RELOAD:
  - Lasts one cycle, `fsm_en_o` = 0.
  - Recapture `sh_*`. If `cfg_num_rows` is invalid, keep the old shadow values and set `err_cfg`.
  - Clear `upd_pend`, go to HOLD.
- ABORT:
  - `rd_rst_o` = 1 for RST_CYCLES cycles, `fsm_en_o` = 0, then IDLE.
- Pending flags:
  - `stop` sets `stop_pend` in any non-IDLE state.
  - `cfg_update` sets `upd_pend` in RUN or HOLD.
  - `stop` and `cfg_update` on the same boundary: stop wins and `upd_pend` is dropped.
- `start` outside IDLE is ignored.
- `sh_*` never change while `fsm_en_o` = 1.

## Timing
- Async reset values:
  - `rd_rst_o` = 1 (readout held in reset).
  - All other outputs, `sh_*`, counters and pending flags = 0.
  - State = IDLE.
- First clock after `fsm_rst` release: `rd_rst_o` → 0.
- All outputs are registered.
- `start` sampled at edge k: `busy` = 1 and `rd_rst_o` = 1 after edge k.
- `fsm_en_o` = 1 after edge k+RST_CYCLES+1.
- Boundary on `frame_count`: `fsm_en_o` falls one cycle later when leaving RUN.
  - The readout FSM consumes at most one CLEAR cycle and then parks.
  - No additional frame starts.
- Watchdog compare uses the registered count. The abort issues 1 cycle after the threshold is reached.
- `frame_count` changing in IDLE, ARM, HOLD or ABORT is ignored. `prev_fc` is resynced on entry to RUN.

## Test plan
- Single-frame run:
  - Stimulus: `cfg_num_rows`=4, `cfg_num_frames`=3, `continuous`=0, `start`; emulate `frame_count` stepping 0→1→2→3.
  - Required: `frames_done`=3, `fsm_en_o` low 1 cycle after the third step, `busy`=0.
- Invalid config:
  - Stimulus: `cfg_num_rows`=0 or 801, then `start`.
  - Required: `err_cfg`=1, no `rd_rst_o` pulse, `busy`=0.
- Backpressure:
  - Stimulus: `fifo_afull`=1 at the second boundary.
  - Required: `fsm_en_o`=0 while `fifo_afull`=1; `fsm_en_o`=1 one cycle after it clears; `frames_done` unchanged during HOLD.
- Live reload:
  - Stimulus: `cfg_update` with `cfg_integration`=1000, mid-frame.
  - Required: `sh_integration` unchanged until the boundary; it updates in RELOAD while `fsm_en_o`=0.
- Stop and wrap:
  - Stimulus: `continuous`=1, `frame_count` 1023→0 counts as a boundary; then `stop` mid-frame.
  - Required: run ends at the next boundary.
  - Also: `stop` plus `cfg_update` together → stop wins.
- Watchdog and reset:
  - Stimulus: `cfg_timeout`=50 with `frame_count` frozen.
  - Required: `err_timeout`=1, `rd_rst_o` high for 4 cycles, then IDLE.
  - Also: `fsm_rst` mid-RUN sets `rd_rst_o`=1 and `fsm_en_o`=0 immediately.

Source files
------------

// File: rtl/pdshank_acq_sequencer.sv
// Acquisition sequencer for the pdShank readout FSM: shadows host configuration,
// drives readout enable/reset, counts frames, throttles on FIFO almost-full and
// recovers hung frames through a watchdog.
module pdshank_acq_sequencer #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned MAX_ROWS   = 800
) (
  input  logic        clk_in,
  input  logic        fsm_rst,
  input  logic        start,
  input  logic        stop,
  input  logic        cfg_update,
  input  logic        continuous,
  input  logic [15:0] cfg_num_frames,
  input  logic [9:0]  cfg_num_rows,
  input  logic [31:0] cfg_integration,
  input  logic [59:0] cfg_periods,
  input  logic [3:0]  cfg_data_wait,
  input  logic [31:0] cfg_timeout,
  input  logic [9:0]  frame_count,
  input  logic        fifo_afull,
  output logic        fsm_en_o,
  output logic        rd_rst_o,
  output logic [9:0]  sh_num_rows,
  output logic [31:0] sh_integration,
  output logic [59:0] sh_periods,
  output logic [3:0]  sh_data_wait,
  output logic [15:0] frames_done,
  output logic        busy,
  output logic        err_cfg,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StHold,
    StReload,
    StAbort
  } state_e;

  localparam logic [10:0] MaxRows = 11'(MAX_ROWS);
  localparam logic [7:0]  RstLast = 8'(RST_CYCLES - 1);
  localparam logic [7:0]  RstEnd  = 8'(RST_CYCLES);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [9:0]  prev_fc_q;
  logic [31:0] wd_q;
  logic        stop_pend_q;
  logic        upd_pend_q;

  logic        cfg_valid;
  logic        boundary;
  logic        last_frame;
  logic        stop_now;
  logic        wd_fire;
  logic [15:0] frames_tgt;

  // Decode configuration validity, frame boundaries and exit conditions.
  always_comb begin
    cfg_valid  = (cfg_num_rows != 10'd0) && ({1'b0, cfg_num_rows} <= MaxRows);
    boundary   = (frame_count != prev_fc_q);
    frames_tgt = (cfg_num_frames == 16'd0) ? 16'd1 : cfg_num_frames;
    last_frame = !continuous && (({1'b0, frames_done} + 17'd1) >= {1'b0, frames_tgt});
    // A stop pulse arriving on the boundary cycle itself still ends the run there.
    stop_now   = stop_pend_q | stop;
    wd_fire    = (cfg_timeout != 32'd0) && (wd_q >= cfg_timeout);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_in or posedge fsm_rst) begin
    if (fsm_rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      prev_fc_q      <= '0;
      wd_q           <= '0;
      stop_pend_q    <= 1'b0;
      upd_pend_q     <= 1'b0;
      fsm_en_o       <= 1'b0;
      rd_rst_o       <= 1'b1;
      sh_num_rows    <= '0;
      sh_integration <= '0;
      sh_periods     <= '0;
      sh_data_wait   <= '0;
      frames_done    <= '0;
      busy           <= 1'b0;
      err_cfg        <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      // Pending-flag capture; state handling below may override these.
      if ((state_q != StIdle) && stop) stop_pend_q <= 1'b1;
      if (((state_q == StRun) || (state_q == StHold)) && cfg_update && !stop_now) begin
        upd_pend_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          fsm_en_o <= 1'b0;
          rd_rst_o <= 1'b0;
          busy     <= 1'b0;
          if (start) begin
            if (cfg_valid) begin
              sh_num_rows    <= cfg_num_rows;
              sh_integration <= cfg_integration;
              sh_periods     <= cfg_periods;
              sh_data_wait   <= cfg_data_wait;
              frames_done    <= '0;
              err_cfg        <= 1'b0;
              err_timeout    <= 1'b0;
              stop_pend_q    <= 1'b0;
              upd_pend_q     <= 1'b0;
              cnt_q          <= '0;
              rd_rst_o       <= 1'b1;
              busy           <= 1'b1;
              state_q        <= StArm;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end

        StArm: begin
          // Reset held RST_CYCLES cycles, then one quiet cycle before enabling.
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == RstLast) rd_rst_o <= 1'b0;
          if (cnt_q == RstEnd) begin
            prev_fc_q <= '0;
            wd_q      <= '0;
            fsm_en_o  <= 1'b1;
            state_q   <= StRun;
          end
        end

        StRun: begin
          if (stop_now) upd_pend_q <= 1'b0;
          if (boundary) begin
            prev_fc_q <= frame_count;
            wd_q      <= '0;
            if (frames_done != 16'hFFFF) frames_done <= frames_done + 16'd1;
            if (stop_now || last_frame) begin
              fsm_en_o    <= 1'b0;
              busy        <= 1'b0;
              stop_pend_q <= 1'b0;
              upd_pend_q  <= 1'b0;
              state_q     <= StIdle;
            end else if (upd_pend_q) begin
              fsm_en_o <= 1'b0;
              state_q  <= StReload;
            end else if (fifo_afull) begin
              fsm_en_o <= 1'b0;
              state_q  <= StHold;
            end
          end else if (wd_fire) begin
            err_timeout <= 1'b1;
            fsm_en_o    <= 1'b0;
            rd_rst_o    <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StAbort;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end

        StHold: begin
          fsm_en_o <= 1'b0;
          if (stop_now) begin
            busy        <= 1'b0;
            stop_pend_q <= 1'b0;
            upd_pend_q  <= 1'b0;
            state_q     <= StIdle;
          end else if (!fifo_afull) begin
            // Readout may have moved frame_count while parked; resync so it is not a boundary.
            prev_fc_q <= frame_count;
            fsm_en_o  <= 1'b1;
            state_q   <= StRun;
          end
        end

        StReload: begin
          fsm_en_o <= 1'b0;
          if (cfg_valid) begin
            sh_num_rows    <= cfg_num_rows;
            sh_integration <= cfg_integration;
            sh_periods     <= cfg_periods;
            sh_data_wait   <= cfg_data_wait;
          end else begin
            err_cfg <= 1'b1;
          end
          upd_pend_q <= 1'b0;
          state_q    <= StHold;
        end

        StAbort: begin
          fsm_en_o <= 1'b0;
          cnt_q    <= cnt_q + 8'd1;
          if (cnt_q == RstLast) begin
            rd_rst_o    <= 1'b0;
            busy        <= 1'b0;
            stop_pend_q <= 1'b0;
            upd_pend_q  <= 1'b0;
            state_q     <= StIdle;
          end
        end

        default: begin
          fsm_en_o <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdshank_acq_sequencer.sv
// Directed bench for pdshank_acq_sequencer: expected values are queued when
// stimulus is applied and popped against DUT outputs after the clock edge.
module tb_pdshank_acq_sequencer;

  logic        clk_in = 1'b0;
  logic        fsm_rst;
  logic        start, stop, cfg_update, continuous;
  logic [15:0] cfg_num_frames;
  logic [9:0]  cfg_num_rows;
  logic [31:0] cfg_integration;
  logic [59:0] cfg_periods;
  logic [3:0]  cfg_data_wait;
  logic [31:0] cfg_timeout;
  logic [9:0]  frame_count;
  logic        fifo_afull;
  logic        fsm_en_o, rd_rst_o;
  logic [9:0]  sh_num_rows;
  logic [31:0] sh_integration;
  logic [59:0] sh_periods;
  logic [3:0]  sh_data_wait;
  logic [15:0] frames_done;
  logic        busy, err_cfg, err_timeout;

  pdshank_acq_sequencer #(.RST_CYCLES(4), .MAX_ROWS(800)) dut (
    .clk_in          (clk_in),
    .fsm_rst         (fsm_rst),
    .start           (start),
    .stop            (stop),
    .cfg_update      (cfg_update),
    .continuous      (continuous),
    .cfg_num_frames  (cfg_num_frames),
    .cfg_num_rows    (cfg_num_rows),
    .cfg_integration (cfg_integration),
    .cfg_periods     (cfg_periods),
    .cfg_data_wait   (cfg_data_wait),
    .cfg_timeout     (cfg_timeout),
    .frame_count     (frame_count),
    .fifo_afull      (fifo_afull),
    .fsm_en_o        (fsm_en_o),
    .rd_rst_o        (rd_rst_o),
    .sh_num_rows     (sh_num_rows),
    .sh_integration  (sh_integration),
    .sh_periods      (sh_periods),
    .sh_data_wait    (sh_data_wait),
    .frames_done     (frames_done),
    .busy            (busy),
    .err_cfg         (err_cfg),
    .err_timeout     (err_timeout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } sb_item_t;

  sb_item_t sb_q[$];
  int passed = 0;
  int total  = 0;
  int n_wait;

  task automatic sb_push(input string tag, input logic [63:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    sb_q.push_back(it);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    sb_item_t it;
    total++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_empty observed=%0h expected=<none>", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.val) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.val);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Start pulse then wait until the readout enable is asserted (edge k+5).
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    fsm_rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_update = 1'b0; continuous = 1'b0;
    cfg_num_frames = 16'd3; cfg_num_rows = 10'd4; cfg_integration = 32'h1234;
    cfg_periods = 60'h123_4567_89AB_CDEF; cfg_data_wait = 4'd5; cfg_timeout = 32'd0;
    frame_count = 10'd0; fifo_afull = 1'b0;

    // Reset values
    sb_push("rst_rd_rst", 1); sb_push("rst_fsm_en", 0); sb_push("rst_busy", 0);
    sb_push("rst_frames", 0); sb_push("rst_sh_int", 0);
    #2;
    sb_check(rd_rst_o); sb_check(fsm_en_o); sb_check(busy);
    sb_check(frames_done); sb_check(sh_integration);
    tick();
    fsm_rst = 1'b0;
    sb_push("rel_rd_rst", 0);
    tick();
    sb_check(rd_rst_o);

    // Single-frame-count run: 3 frames
    start = 1'b1;
    sb_push("arm_busy", 1); sb_push("arm_rd_rst", 1); sb_push("arm_sh_rows", 4);
    sb_push("arm_sh_per", 60'h123_4567_89AB_CDEF); sb_push("arm_fsm_en", 0);
    tick();
    start = 1'b0;
    sb_check(busy); sb_check(rd_rst_o); sb_check(sh_num_rows);
    sb_check(sh_periods); sb_check(fsm_en_o);
    repeat (3) tick();
    sb_push("arm_rd_rst_k3", 1);
    sb_check(rd_rst_o);
    tick();
    sb_push("arm_rd_rst_k4", 0); sb_push("arm_en_k4", 0);
    sb_check(rd_rst_o); sb_check(fsm_en_o);
    tick();
    sb_push("run_en_k5", 1);
    sb_check(fsm_en_o);
    for (int f = 1; f <= 3; f++) begin
      repeat (3) tick();
      frame_count = 10'(f);
      sb_push("run_frames", 64'(f));
      tick();
      sb_check(frames_done);
    end
    sb_push("done_en", 0); sb_push("done_busy", 0);
    sb_check(fsm_en_o); sb_check(busy);

    // Invalid configuration: 0 rows and 801 rows
    cfg_num_rows = 10'd0;
    start = 1'b1;
    sb_push("inv0_err", 1); sb_push("inv0_busy", 0); sb_push("inv0_rd_rst", 0);
    tick();
    start = 1'b0;
    sb_check(err_cfg); sb_check(busy); sb_check(rd_rst_o);
    cfg_num_rows = 10'd801;
    start = 1'b1;
    sb_push("inv801_err", 1); sb_push("inv801_busy", 0); sb_push("inv801_rd_rst", 0);
    tick();
    start = 1'b0;
    sb_check(err_cfg); sb_check(busy);
    tick();
    sb_check(rd_rst_o);

    // Backpressure
    cfg_num_rows = 10'd4; cfg_num_frames = 16'd10; frame_count = 10'd0;
    sb_push("bp_err_cleared", 0); sb_push("bp_en", 1);
    do_start();
    sb_check(err_cfg); sb_check(fsm_en_o);
    frame_count = 10'd1;
    sb_push("bp_fd1", 1);
    tick();
    sb_check(frames_done);
    frame_count = 10'd2; fifo_afull = 1'b1;
    sb_push("bp_fd2", 2); sb_push("bp_hold_en", 0);
    tick();
    sb_check(frames_done); sb_check(fsm_en_o);
    frame_count = 10'd3;
    repeat (3) tick();
    sb_push("bp_hold_en2", 0); sb_push("bp_hold_fd", 2);
    sb_check(fsm_en_o); sb_check(frames_done);
    fifo_afull = 1'b0;
    sb_push("bp_resume_en", 1);
    tick();
    sb_check(fsm_en_o);
    sb_push("bp_resync_fd", 2);
    tick();
    sb_check(frames_done);
    frame_count = 10'd4;
    sb_push("bp_fd3", 3);
    tick();
    sb_check(frames_done);

    // Live reload mid-frame
    cfg_integration = 32'd1000; cfg_update = 1'b1;
    sb_push("rl_sh_hold", 32'h1234);
    tick();
    cfg_update = 1'b0;
    sb_check(sh_integration);
    tick();
    frame_count = 10'd5;
    sb_push("rl_bnd_sh", 32'h1234); sb_push("rl_bnd_en", 0); sb_push("rl_bnd_fd", 4);
    tick();
    sb_check(sh_integration); sb_check(fsm_en_o); sb_check(frames_done);
    sb_push("rl_sh_new", 1000); sb_push("rl_en_low", 0);
    tick();
    sb_check(sh_integration); sb_check(fsm_en_o);
    sb_push("rl_resume_en", 1);
    tick();
    sb_check(fsm_en_o);

    // Graceful stop mid-frame
    stop = 1'b1;
    sb_push("stop_busy_mid", 1);
    tick();
    stop = 1'b0;
    sb_check(busy);
    frame_count = 10'd6;
    sb_push("stop_busy", 0); sb_push("stop_en", 0); sb_push("stop_fd", 5);
    tick();
    sb_check(busy); sb_check(fsm_en_o); sb_check(frames_done);

    // Continuous with 1023 -> 0 wrap, then stop + cfg_update together
    continuous = 1'b1; cfg_num_frames = 16'd1; frame_count = 10'd0;
    do_start();
    frame_count = 10'd1023;
    sb_push("wr_fd1", 1); sb_push("wr_busy1", 1);
    tick();
    sb_check(frames_done); sb_check(busy);
    frame_count = 10'd0;
    sb_push("wr_fd2", 2); sb_push("wr_busy2", 1);
    tick();
    sb_check(frames_done); sb_check(busy);
    stop = 1'b1; cfg_update = 1'b1; cfg_integration = 32'd777;
    tick();
    stop = 1'b0; cfg_update = 1'b0;
    tick();
    frame_count = 10'd1;
    sb_push("su_busy", 0); sb_push("su_sh_int", 1000); sb_push("su_fd", 3);
    tick();
    sb_check(busy); sb_check(sh_integration); sb_check(frames_done);
    tick();
    sb_push("su_sh_int_idle", 1000);
    sb_check(sh_integration);

    // Watchdog with frame_count frozen
    cfg_timeout = 32'd50; frame_count = 10'd0;
    do_start();
    n_wait = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      n_wait = i;
      if (rd_rst_o) break;
    end
    sb_push("wd_latency", 51); sb_push("wd_err", 1); sb_push("wd_en", 0);
    sb_check(64'(n_wait)); sb_check(err_timeout); sb_check(fsm_en_o);
    repeat (3) tick();
    sb_push("wd_rd_rst_4th", 1); sb_push("wd_busy_abort", 1);
    sb_check(rd_rst_o); sb_check(busy);
    tick();
    sb_push("wd_rd_rst_end", 0); sb_push("wd_busy_end", 0);
    sb_check(rd_rst_o); sb_check(busy);

    // MAX_ROWS is legal; async reset mid-RUN
    cfg_timeout = 32'd0; cfg_num_rows = 10'd800;
    sb_push("max_rows_en", 1); sb_push("max_rows_sh", 800); sb_push("max_err_to", 0);
    do_start();
    sb_check(fsm_en_o); sb_check(sh_num_rows); sb_check(err_timeout);
    fsm_rst = 1'b1;
    sb_push("ar_rd_rst", 1); sb_push("ar_en", 0); sb_push("ar_busy", 0);
    #1;
    sb_check(rd_rst_o); sb_check(fsm_en_o); sb_check(busy);
    tick();
    fsm_rst = 1'b0;
    sb_push("ar_rel_rd_rst", 0);
    tick();
    sb_check(rd_rst_o);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
